// File: rtl/vpu_writeback.sv
// vpu_writeback: round-robin result arbiter driving the vector register file write port.
// Define VPU_WB_AGNOSTIC_EN for the tail/mask-agnostic policy (all-ones fill of inactive bytes).
module vpu_writeback #(
    parameter int VLEN    = 64,
    parameter int NUM_SRC = 3,
    parameter int VL_W    = $clog2(VLEN/8)+1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_SRC-1:0]             wb_valid_i,
    output logic [NUM_SRC-1:0]             wb_ready_o,
    input  logic [NUM_SRC-1:0][4:0]        wb_addr_i,
    input  logic [NUM_SRC-1:0][VLEN-1:0]   wb_data_i,
    input  logic [NUM_SRC-1:0][1:0]        wb_sew_i,
    input  logic [NUM_SRC-1:0]             wb_vm_i,
    input  logic [NUM_SRC-1:0][VL_W-1:0]   wb_vstart_i,
    input  logic [NUM_SRC-1:0][VL_W-1:0]   wb_vl_i,
    input  logic [VLEN-1:0]                vreg_v0_i,
    output logic                           vreg_write_en_o,
    output logic [4:0]                     vreg_write_addr_o,
    output logic [VLEN/8-1:0]              vreg_write_bweb_o,
    output logic [VLEN-1:0]                vreg_write_data_o,
    output logic                           done_valid_o,
    output logic [4:0]                     done_addr_o
);
    localparam int NB = VLEN/8;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Handshake: a source transfers in the cycle where wb_valid_i[s] and wb_ready_o[s] are both 1;
    // ready is combinational from valid and never depends on any downstream stall.
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] win_idx, cand;
    logic          win_any;

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            cand = PW'((int'(rr_ptr_q) + off) % NUM_SRC);
            if (!win_any && wb_valid_i[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_any)
            rr_ptr_d = (win_idx == PW'(NUM_SRC-1)) ? '0 : win_idx + PW'(1);
    end

    // Gated by reset so ready drops immediately when rst_ni falls.
    assign wb_ready_o = (win_any && rst_ni) ? (NUM_SRC'(1) << win_idx) : '0;

    logic [4:0]      sel_addr;
    logic [VLEN-1:0] sel_data;
    logic [1:0]      sel_sew;
    logic            sel_vm;
    logic [VL_W-1:0] sel_vstart, sel_vl;

    assign sel_addr   = wb_addr_i[win_idx];
    assign sel_data   = wb_data_i[win_idx];
    assign sel_sew    = wb_sew_i[win_idx];
    assign sel_vm     = wb_vm_i[win_idx];
    assign sel_vstart = wb_vstart_i[win_idx];
    assign sel_vl     = wb_vl_i[win_idx];

    // A v0 write still sitting on the port has not reached the register file yet.
    logic [VLEN-1:0] v0_eff;

    always_comb begin
        v0_eff = vreg_v0_i;
        if (vreg_write_en_o && (vreg_write_addr_o == 5'd0)) begin
            for (int k = 0; k < NB; k++)
                if (vreg_write_bweb_o[k])
                    v0_eff[8*k +: 8] = vreg_write_data_o[8*k +: 8];
        end
    end

    logic [VL_W-1:0] elem_cnt, vl_clamp, elem;
    logic [VLEN-1:0] v0_shift;
    logic [NB-1:0]   act, bweb_d;
    logic [VLEN-1:0] data_d;

    always_comb begin
        elem_cnt = VL_W'(NB) >> sel_sew;
        vl_clamp = (sel_vl > elem_cnt) ? elem_cnt : sel_vl;
        act      = '0;
        elem     = '0;
        v0_shift = '0;
        // Each byte belongs to element k >> sew; the mask bit for element i is v0_eff[i].
        for (int k = 0; k < NB; k++) begin
            elem     = VL_W'(k) >> sel_sew;
            v0_shift = v0_eff >> elem;
            act[k]   = (sel_vstart <= elem) && (elem < vl_clamp) && (sel_vm || v0_shift[0]);
        end
`ifdef VPU_WB_AGNOSTIC_EN
        bweb_d = (sel_vstart < vl_clamp) ? '1 : '0;
        data_d = sel_data;
        for (int k = 0; k < NB; k++)
            if (!act[k])
                data_d[8*k +: 8] = 8'hFF;
`else
        bweb_d = act;
        data_d = sel_data;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q          <= '0;
            vreg_write_en_o   <= 1'b0;
            vreg_write_addr_o <= '0;
            vreg_write_bweb_o <= '0;
            vreg_write_data_o <= '0;
            done_valid_o      <= 1'b0;
            done_addr_o       <= '0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            done_valid_o    <= win_any;
            vreg_write_en_o <= win_any && (|bweb_d);
            if (win_any) begin
                vreg_write_addr_o <= sel_addr;
                vreg_write_bweb_o <= bweb_d;
                vreg_write_data_o <= data_d;
                done_addr_o       <= sel_addr;
            end
        end
    end

endmodule

// File: tb/tb_vpu_writeback.sv
// tb_vpu_writeback: scoreboard bench for vpu_writeback with an element-level reference model.
`timescale 1ns/1ps
module tb_vpu_writeback;
    localparam int VLEN    = 64;
    localparam int NUM_SRC = 3;
    localparam int VL_W    = $clog2(VLEN/8)+1;
    localparam int NB      = VLEN/8;
    localparam int EW      = 1 + 5 + NB + VLEN + 5;

    logic                         clk_i;
    logic                         rst_ni;
    logic [NUM_SRC-1:0]           wb_valid;
    logic [NUM_SRC-1:0]           wb_ready;
    logic [NUM_SRC-1:0][4:0]      wb_addr;
    logic [NUM_SRC-1:0][VLEN-1:0] wb_data;
    logic [NUM_SRC-1:0][1:0]      wb_sew;
    logic [NUM_SRC-1:0]           wb_vm;
    logic [NUM_SRC-1:0][VL_W-1:0] wb_vstart;
    logic [NUM_SRC-1:0][VL_W-1:0] wb_vl;
    logic [VLEN-1:0]              vreg_v0;
    logic                         wr_en;
    logic [4:0]                   wr_addr;
    logic [NB-1:0]                wr_bweb;
    logic [VLEN-1:0]              wr_data;
    logic                         done_valid;
    logic [4:0]                   done_addr;

    vpu_writeback #(.VLEN(VLEN), .NUM_SRC(NUM_SRC), .VL_W(VL_W)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .wb_valid_i        (wb_valid),
        .wb_ready_o        (wb_ready),
        .wb_addr_i         (wb_addr),
        .wb_data_i         (wb_data),
        .wb_sew_i          (wb_sew),
        .wb_vm_i           (wb_vm),
        .wb_vstart_i       (wb_vstart),
        .wb_vl_i           (wb_vl),
        .vreg_v0_i         (vreg_v0),
        .vreg_write_en_o   (wr_en),
        .vreg_write_addr_o (wr_addr),
        .vreg_write_bweb_o (wr_bweb),
        .vreg_write_data_o (wr_data),
        .done_valid_o      (done_valid),
        .done_addr_o       (done_addr)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model state: arbitration pointer and the write last placed on the port
    int              rr_ptr = 0;
    logic            st_en = 1'b0;
    logic [4:0]      st_addr = '0;
    logic [NB-1:0]   st_bweb = '0;
    logic [VLEN-1:0] st_data = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_pkt(input logic [1:0] sew, input logic vm,
                                      input logic [VL_W-1:0] vstart, input logic [VL_W-1:0] vl,
                                      input logic [VLEN-1:0] v0, input logic [VLEN-1:0] d,
                                      output logic [NB-1:0] bweb, output logic [VLEN-1:0] data);
        int eb, cnt, vlc;
        logic [NB-1:0] active;
        eb     = 1 << sew;
        cnt    = NB / eb;
        vlc    = (int'(vl) > cnt) ? cnt : int'(vl);
        active = '0;
        for (int i = 0; i < cnt; i++)
            if (i >= int'(vstart) && i < vlc && (vm || v0[i]))
                for (int j = 0; j < eb; j++)
                    active[i*eb + j] = 1'b1;
`ifdef VPU_WB_AGNOSTIC_EN
        bweb = (int'(vstart) < vlc) ? '1 : '0;
        data = d;
        for (int k = 0; k < NB; k++)
            if (!active[k])
                data[8*k +: 8] = 8'hFF;
`else
        bweb = active;
        data = d;
`endif
    endfunction

    // driver: inputs are set right after a negedge; step checks ready, predicts, waits a cycle
    task automatic step();
        int win;
        logic [NUM_SRC-1:0] exp_rdy;
        logic [VLEN-1:0] v0e;
        logic [NB-1:0] b;
        logic [VLEN-1:0] d;
        #1;
        win = -1;
        for (int off = 0; off < NUM_SRC; off++) begin
            int s;
            s = (rr_ptr + off) % NUM_SRC;
            if (win < 0 && wb_valid[s]) win = s;
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        check("ready", 128'(wb_ready), 128'(exp_rdy));
        if (win >= 0) begin
            v0e = vreg_v0;
            if (st_en && st_addr == 5'd0)
                for (int k = 0; k < NB; k++)
                    if (st_bweb[k]) v0e[8*k +: 8] = st_data[8*k +: 8];
            model_pkt(wb_sew[win], wb_vm[win], wb_vstart[win], wb_vl[win], v0e, wb_data[win], b, d);
            exp_q.push_back({|b, wb_addr[win], b, d, wb_addr[win]});
            st_en   = |b;
            st_addr = wb_addr[win];
            st_bweb = b;
            st_data = d;
            rr_ptr  = (win + 1) % NUM_SRC;
        end else begin
            st_en = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic set_src(input int s, input logic [4:0] a, input logic [1:0] sew, input logic vm,
                           input logic [VL_W-1:0] vs, input logic [VL_W-1:0] vl,
                           input logic [VLEN-1:0] d);
        wb_addr[s]   = a;
        wb_sew[s]    = sew;
        wb_vm[s]     = vm;
        wb_vstart[s] = vs;
        wb_vl[s]     = vl;
        wb_data[s]   = d;
    endtask

    task automatic rand_src(input int s);
        logic [4:0] a;
        a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        set_src(s, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                VL_W'($urandom_range(0, 9)), VL_W'($urandom_range(0, 15)), {$urandom, $urandom});
    endtask

    // monitor / scoreboard
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_ni) begin
                if (done_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done addr %0d expected no completion", done_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", 128'({wr_en, wr_addr, wr_bweb, wr_data, done_addr}), 128'(e));
                    end
                end else begin
                    check("idle_en", 128'(wr_en), 128'(0));
                end
            end
        end
    end

    initial begin
        rst_ni   = 1'b1;
        wb_valid = '0;
        wb_addr  = '0;
        wb_data  = '0;
        wb_sew   = '0;
        wb_vm    = '0;
        wb_vstart = '0;
        wb_vl    = '0;
        vreg_v0  = '0;
        #3;
        rst_ni   = 1'b0;
        wb_valid = 3'b111;
        #1;
        check("rst_en", 128'(wr_en), 128'(0));
        check("rst_done", 128'(done_valid), 128'(0));
        check("rst_ready", 128'(wb_ready), 128'(0));
        check("rst_bus", 128'({wr_addr, wr_bweb, wr_data, done_addr}), 128'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // all sources busy: grants rotate 001,010,100,001
        for (int s = 0; s < NUM_SRC; s++) rand_src(s);
        wb_valid = 3'b111;
        repeat (4) step();
        wb_valid = '0;
        step();

        // directed byte-enable cases
        set_src(0, 5'd5, 2'd0, 1'b1, 4'd0, 4'd8, 64'h0123456789ABCDEF);
        wb_valid = 3'b001;
        step();
        set_src(1, 5'd7, 2'd1, 1'b1, 4'd1, 4'd3, {$urandom, $urandom});
        wb_valid = 3'b010;
        step();
        set_src(2, 5'd9, 2'd2, 1'b0, 4'd0, 4'd2, {$urandom, $urandom});
        vreg_v0  = 64'h05;
        wb_valid = 3'b100;
        step();
        vreg_v0 = 64'h04;
        step();
        wb_valid = '0;
        step();

        // v0 written then immediately used as a mask
        set_src(0, 5'd0, 2'd0, 1'b1, 4'd0, 4'd8, {$urandom, 24'h0, 8'h0A});
        vreg_v0  = 64'h0;
        wb_valid = 3'b001;
        step();
        set_src(1, 5'd3, 2'd0, 1'b0, 4'd0, 4'd8, {$urandom, $urandom});
        wb_valid = 3'b010;
        step();
        wb_valid = '0;
        step();

        // randomized traffic
        repeat (400) begin
            for (int s = 0; s < NUM_SRC; s++) rand_src(s);
            wb_valid = NUM_SRC'($urandom_range(0, 7));
            vreg_v0  = {$urandom, $urandom};
            step();
        end

        // reset with a write on the port
        for (int s = 0; s < NUM_SRC; s++) rand_src(s);
        wb_valid = 3'b111;
        step();
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_en", 128'(wr_en), 128'(0));
        check("midrst_done", 128'(done_valid), 128'(0));
        check("midrst_ready", 128'(wb_ready), 128'(0));
        rr_ptr = 0;
        st_en  = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) step();
        wb_valid = '0;
        repeat (2) step();

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
